sparc_ram_responder: RTL and testbench
======================================

Name: sparc_ram_responder

Overview:
Memory-side responder for the control unit's MOV/ReadWrite/Type memory handshake. It holds the 512-byte big-endian byte-addressed main memory that the control unit fetches instructions from and that the MDR/MAR path loads and stores through. It answers each MOV request with MFC after a fixed latency, under a 4-phase handshake. Sits between the datapath (MAR drives Address, MDR drives DataIn and captures DataOut) and the control unit (drives MOV, ReadWrite and Type; samples MFC).

Parameters:
- LATENCY, 2, cycles spent in ACCESS before commit; legal range 1..15.
- ADDR_W, 9, byte-address width; memory depth is 2**ADDR_W bytes.

Ports:
- Clk  in  1  system clock, rising-edge.
- Clr  in  1  reset, asynchronous, active-high.
- MOV  in  1  request strobe from the control unit; level-held until MFC is seen.
- ReadWrite  in  1  1 = read (load/fetch), 0 = write (store).
- Type  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- Address  in  ADDR_W  byte address from MAR.
- DataIn  in  32  store data from MDR, right-justified (byte in [7:0], halfword in [15:0]).
- DataOut  out  32  load data, zero-extended and right-justified.
- MFC  out  1  memory-function-complete.
- AlignErr  out  1  qualifies MFC; 1 = request rejected.

Behaviour:
- Reset: asynchronous, active-high, one clock.
  - State goes to IDLE; MFC=0, AlignErr=0, DataOut=0, latency counter=0.
  - Memory contents are not cleared. Preload through the write path or hierarchical access.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On a rising edge with MOV=1, latch Address, Type, ReadWrite and DataIn.
  - Misaligned or reserved request goes to DONE with AlignErr=1:
    - halfword with Address[0]=1;
    - word with Address[1:0]!=0;
    - Type=11.
  - Otherwise go to ACCESS with counter=0.
- ACCESS:
  - Counter increments each cycle.
  - When counter==LATENCY-1 and MOV is still 1, commit and go to DONE.
  - Net latency: MOV sampled at edge n gives MFC=1 after edge n+LATENCY+1 (default 3 edges).
- Commit:
  - Read: DataOut is loaded from the latched address, big-endian.
    - byte: {24'b0, M[a]}.
    - halfword: {16'b0, M[a], M[a+1]}.
    - word: {M[a], M[a+1], M[a+2], M[a+3]}.
  - Write: all addressed bytes are written in the same edge, with the most significant byte at the lowest address.
- DONE:
  - MFC=1, held until MOV=0.
  - On MOV=0, the next edge clears MFC and AlignErr and returns to IDLE.
  - DataOut holds its value until the next committed read; writes and rejected requests never change it.
- Abort: MOV=0 while in ACCESS returns to IDLE without commit, so no memory or DataOut change and MFC stays 0.
- Reset mid-operation: no partial write is possible, because commit is single-edge.
- Alignment guarantees that no access crosses the top of memory, so there is no wrap-around. Word at 0x1FC is legal.
- Back-to-back requests: a new request is accepted only from IDLE. The minimum spacing is one idle cycle after MFC falls.
- Inputs are ignored outside IDLE; latched copies are used.

Decomposition:
- Shared package holds:
  - Type encodings: TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_RSVD;
  - ReadWrite encodings: RW_READ=1, RW_WRITE=0;
  - state encodings.
- Sub-module sparc_byte_ram:
  - 2**ADDR_W x 8 storage;
  - 4 byte lanes, each with its own write enable, written in one edge;
  - combinational 4-byte read at a given aligned base.
- The responder holds only the FSM, latches, alignment check and lane steering.

Test Plan:
- Word write then read: write 0xDEADBEEF at 0x010, then read a word at 0x010.
  - DataOut=0xDEADBEEF, AlignErr=0.
  - Byte reads at 0x010..0x013 return 0xDE, 0xAD, 0xBE, 0xEF.
  - MFC rises 3 edges after MOV is sampled.
- Sub-word access: byte write 0x7F at 0x021 and halfword write 0x1234 at 0x022, then word read at 0x020.
  - DataOut=0x007F1234 (byte 0x020 pre-zeroed).
  - Halfword read at 0x022 returns 0x00001234.
- Misaligned and reserved requests: word read at 0x005, halfword write at 0x003, Type=11.
  - Each gives MFC=1 and AlignErr=1 after 1 edge.
  - Memory and DataOut are unchanged.
- Handshake:
  - Hold MOV=1 for 10 cycles after MFC: MFC stays 1.
  - Drop MOV: MFC=0 next edge.
  - New MOV accepted only after that.
- Abort and reset:
  - Drop MOV in the first ACCESS cycle of a word write to 0x040: M[0x040..0x043] is unchanged and MFC never rises.
  - Pulse Clr mid-ACCESS of a write to 0x044: outputs go to 0 immediately and the memory at 0x044 is unchanged.
- Boundary: word write then read of 0xCAFEF00D at 0x1FC.
  - Returns 0xCAFEF00D.
  - Address 0x000 is unaffected.

Source files
------------

// File: rtl/sparc_ram_responder_pkg.sv
// ============================================================================
// sparc_ram_responder_pkg : shared encodings for the memory responder slice
// Rev 1.0
// ============================================================================
`default_nettype none

package sparc_ram_responder_pkg;

    typedef enum logic [1:0] {
        TYPE_BYTE = 2'b00,
        TYPE_HALF = 2'b01,
        TYPE_WORD = 2'b10,
        TYPE_RSVD = 2'b11
    } type_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam int CNT_W = 4;

    function automatic logic is_rejected(input logic [1:0] lo, input type_e t);
        case (t)
            TYPE_BYTE: return 1'b0;
            TYPE_HALF: return lo[0];
            TYPE_WORD: return |lo;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sparc_ram_responder_if.sv
// ============================================================================
// sparc_ram_responder_if : MOV/ReadWrite/Type memory handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface sparc_ram_responder_if #(
    parameter int ADDR_W = 9
);
    logic              MOV;
    logic              ReadWrite;
    logic [1:0]        Type;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MFC;
    logic              AlignErr;

    modport master (
        output MOV, ReadWrite, Type, Address, DataIn,
        input  DataOut, MFC, AlignErr
    );

    modport slave (
        input  MOV, ReadWrite, Type, Address, DataIn,
        output DataOut, MFC, AlignErr
    );
endinterface

`default_nettype wire

// File: rtl/sparc_ram_responder_ram.sv
// ============================================================================
// sparc_byte_ram : byte-wide storage with four lane-enabled write ports and a
//                  combinational big-endian 4-byte read at an aligned base
// Rev 1.0
// ============================================================================
`default_nettype none

module sparc_byte_ram #(
    parameter int ADDR_W = 9
) (
    input  wire logic              clk,
    input  wire logic [ADDR_W-3:0] base_i,
    input  wire logic [3:0]        we_i,
    input  wire logic [31:0]       wdata_i,
    output logic      [31:0]       rdata_o
);
    logic [7:0] mem [2**ADDR_W];

    // Lane 3 (bits 31:24) is the lowest address of the aligned group.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i[3-l]) begin
                mem[{base_i, 2'(l)}] <= wdata_i[31-8*l -: 8];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd_lane
        assign rdata_o[31-8*g -: 8] = mem[{base_i, 2'(g)}];
    end

endmodule

`default_nettype wire

// File: rtl/sparc_ram_responder.sv
// ============================================================================
// sparc_ram_responder : 4-phase MOV/MFC memory responder with fixed latency
// Rev 1.0
// ============================================================================
`default_nettype none

module sparc_ram_responder
    import sparc_ram_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 9
) (
    input  wire logic              Clk,
    input  wire logic              Clr,
    sparc_ram_responder_if.slave   bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    type_e             type_q;
    logic              rw_q;
    logic [31:0]       din_q;
    logic              err_q;
    logic [31:0]       dout_q;
    logic              mfc_q, mfc_d;
    logic              aerr_q, aerr_d;

    logic              w_accept;
    logic              w_commit;
    logic [3:0]        w_lane_mask;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic [31:0]       w_rd_val;

    assign w_accept = (state_q == ST_IDLE) && bus.MOV;
    assign w_commit = (state_q == ST_ACCESS) && bus.MOV &&
                      (cnt_q == CNT_W'(LATENCY - 1));

    // ---------------- state register ----------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.MOV) begin
                    state_d = is_rejected(bus.Address[1:0], type_e'(bus.Type)) ?
                              ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!bus.MOV)      state_d = ST_IDLE;
                else if (w_commit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.MOV) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // MFC lags entry into DONE by one edge and drops on the edge that sees MOV low.
    always_comb begin
        mfc_d  = (state_q == ST_DONE) && bus.MOV;
        aerr_d = (state_q == ST_DONE) && bus.MOV && err_q;
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            mfc_q  <= 1'b0;
            aerr_q <= 1'b0;
            cnt_q  <= '0;
            dout_q <= '0;
            addr_q <= '0;
            type_q <= TYPE_BYTE;
            rw_q   <= RW_READ;
            din_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            mfc_q  <= mfc_d;
            aerr_q <= aerr_d;
            if (w_accept) begin
                addr_q <= bus.Address;
                type_q <= type_e'(bus.Type);
                rw_q   <= bus.ReadWrite;
                din_q  <= bus.DataIn;
                err_q  <= is_rejected(bus.Address[1:0], type_e'(bus.Type));
                cnt_q  <= '0;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (w_commit && (rw_q == RW_READ)) begin
                dout_q <= w_rd_val;
            end
        end
    end

    // ---------------- lane steering ----------------
    always_comb begin
        w_lane_mask = 4'b0000;
        w_wdata     = 32'h0;
        w_rd_val    = 32'h0;
        case (type_q)
            TYPE_BYTE: begin
                w_lane_mask = 4'b1000 >> addr_q[1:0];
                w_wdata     = {4{din_q[7:0]}};
                case (addr_q[1:0])
                    2'd0:    w_rd_val = {24'h0, w_rdata[31:24]};
                    2'd1:    w_rd_val = {24'h0, w_rdata[23:16]};
                    2'd2:    w_rd_val = {24'h0, w_rdata[15:8]};
                    default: w_rd_val = {24'h0, w_rdata[7:0]};
                endcase
            end
            TYPE_HALF: begin
                w_lane_mask = addr_q[1] ? 4'b0011 : 4'b1100;
                w_wdata     = {2{din_q[15:0]}};
                w_rd_val    = addr_q[1] ? {16'h0, w_rdata[15:0]} : {16'h0, w_rdata[31:16]};
            end
            TYPE_WORD: begin
                w_lane_mask = 4'b1111;
                w_wdata     = din_q;
                w_rd_val    = w_rdata;
            end
            default: begin
                w_lane_mask = 4'b0000;
            end
        endcase
        w_we = (w_commit && (rw_q == RW_WRITE)) ? w_lane_mask : 4'b0000;
    end

    sparc_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clk),
        .base_i  (addr_q[ADDR_W-1:2]),
        .we_i    (w_we),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata)
    );

    assign bus.DataOut  = dout_q;
    assign bus.MFC      = mfc_q;
    assign bus.AlignErr = aerr_q;

endmodule

`default_nettype wire

// File: tb/tb_sparc_ram_responder.sv
// ============================================================================
// tb_sparc_ram_responder : directed self-checking bench for the responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sparc_ram_responder;
    localparam int ADDR_W = 9;
    localparam int LAT    = 2;
    // Edges counted from the MOV-sampling edge up to and including the MFC edge.
    localparam int OK_EDGES  = LAT + 2;
    localparam int REJ_EDGES = 2;

    logic Clk = 1'b0;
    logic Clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sparc_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    sparc_ram_responder #(
        .LATENCY (LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic xact(input logic rw, input logic [1:0] ty, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, output logic [31:0] q, output logic ae,
                        output int edges);
        @(negedge Clk);
        bus.MOV = 1'b1; bus.ReadWrite = rw; bus.Type = ty; bus.Address = a; bus.DataIn = d;
        edges = 0;
        do begin
            @(posedge Clk); #1; edges++;
        end while (!bus.MFC && edges < 40);
        q  = bus.DataOut;
        ae = bus.AlignErr;
        @(negedge Clk);
        bus.MOV = 1'b0;
        bus.DataIn = 32'h0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus.MFC !== 1'b0 || bus.AlignErr !== 1'b0 || bus.DataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset: MFC=%b AlignErr=%b DataOut=%h required 0/0/00000000",
                     bus.MFC, bus.AlignErr, bus.DataOut);
        end
        @(negedge Clk); Clr = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] q; logic ae; int e;
        logic [7:0] exp_b [4];
        exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        xact(1'b0, 2'b10, 9'h000, 32'h11223344, q, ae, e);
        xact(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, q, ae, e);
        checks++;
        if (e !== OK_EDGES || ae !== 1'b0) begin
            errors++; $display("FAIL word_write: edges=%0d ae=%b required %0d/0", e, ae, OK_EDGES);
        end
        xact(1'b1, 2'b10, 9'h010, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'hDEADBEEF || ae !== 1'b0 || e !== OK_EDGES) begin
            errors++; $display("FAIL word_read: q=%h ae=%b edges=%0d required deadbeef/0/%0d",
                               q, ae, e, OK_EDGES);
        end
        for (int i = 0; i < 4; i++) begin
            xact(1'b1, 2'b00, 9'(9'h010 + i), 32'h0, q, ae, e);
            checks++;
            if (q !== {24'h0, exp_b[i]}) begin
                errors++; $display("FAIL byte_read[%0d]: q=%h required %h", i, q, {24'h0, exp_b[i]});
            end
        end
    endtask

    task automatic test_subword();
        logic [31:0] q; logic ae; int e;
        xact(1'b0, 2'b00, 9'h020, 32'hFFFFFF00, q, ae, e);
        xact(1'b0, 2'b00, 9'h021, 32'h0000007F, q, ae, e);
        xact(1'b0, 2'b01, 9'h022, 32'hAAAA1234, q, ae, e);
        xact(1'b1, 2'b10, 9'h020, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h007F1234) begin
            errors++; $display("FAIL subword_word_read: q=%h required 007f1234", q);
        end
        xact(1'b1, 2'b01, 9'h022, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h00001234) begin
            errors++; $display("FAIL half_read: q=%h required 00001234", q);
        end
        xact(1'b1, 2'b01, 9'h020, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h0000007F) begin
            errors++; $display("FAIL half_read_lo: q=%h required 0000007f", q);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] q; logic ae; int e;
        xact(1'b1, 2'b10, 9'h005, 32'h0, q, ae, e);
        checks++;
        if (ae !== 1'b1 || e !== REJ_EDGES || q !== 32'h0000007F) begin
            errors++; $display("FAIL mis_word: ae=%b edges=%0d q=%h required 1/%0d/0000007f",
                               ae, e, q, REJ_EDGES);
        end
        xact(1'b0, 2'b01, 9'h003, 32'h0000BEEF, q, ae, e);
        checks++;
        if (ae !== 1'b1 || e !== REJ_EDGES) begin
            errors++; $display("FAIL mis_half: ae=%b edges=%0d required 1/%0d", ae, e, REJ_EDGES);
        end
        xact(1'b1, 2'b11, 9'h010, 32'h0, q, ae, e);
        checks++;
        if (ae !== 1'b1 || e !== REJ_EDGES || q !== 32'h0000007F) begin
            errors++; $display("FAIL rsvd_type: ae=%b edges=%0d q=%h required 1/%0d/0000007f",
                               ae, e, q, REJ_EDGES);
        end
        xact(1'b1, 2'b10, 9'h000, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h11223344 || ae !== 1'b0) begin
            errors++; $display("FAIL mis_mem_intact: q=%h ae=%b required 11223344/0", q, ae);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] q; logic ae; int e; int low_cnt;
        @(negedge Clk);
        bus.MOV = 1'b1; bus.ReadWrite = 1'b1; bus.Type = 2'b10; bus.Address = 9'h010;
        repeat (OK_EDGES) @(posedge Clk);
        #1;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk); bus.Address = 9'h000; bus.Type = 2'b11;
            @(posedge Clk); #1;
            if (bus.MFC !== 1'b1) low_cnt++;
        end
        checks++;
        if (low_cnt != 0 || bus.DataOut !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mfc_hold: low_cycles=%0d DataOut=%h required 0/deadbeef",
                               low_cnt, bus.DataOut);
        end
        @(negedge Clk); bus.MOV = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (bus.MFC !== 1'b0 || bus.AlignErr !== 1'b0) begin
            errors++; $display("FAIL mfc_drop: MFC=%b AlignErr=%b required 0/0", bus.MFC, bus.AlignErr);
        end
        xact(1'b1, 2'b00, 9'h013, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h000000EF || e !== OK_EDGES) begin
            errors++; $display("FAIL back_to_back: q=%h edges=%0d required 000000ef/%0d", q, e, OK_EDGES);
        end
    endtask

    task automatic test_abort_reset();
        logic [31:0] q; logic ae; int e; int rose;
        xact(1'b0, 2'b10, 9'h040, 32'h01020304, q, ae, e);
        xact(1'b0, 2'b10, 9'h044, 32'h55667788, q, ae, e);
        @(negedge Clk);
        bus.MOV = 1'b1; bus.ReadWrite = 1'b0; bus.Type = 2'b10;
        bus.Address = 9'h040; bus.DataIn = 32'hFFFFFFFF;
        @(posedge Clk);
        @(negedge Clk); bus.MOV = 1'b0;
        rose = 0;
        repeat (6) begin
            @(posedge Clk); #1;
            if (bus.MFC !== 1'b0) rose++;
        end
        checks++;
        if (rose != 0) begin
            errors++; $display("FAIL abort_mfc: MFC high cycles=%0d required 0", rose);
        end
        xact(1'b1, 2'b10, 9'h040, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h01020304) begin
            errors++; $display("FAIL abort_mem: q=%h required 01020304", q);
        end
        @(negedge Clk);
        bus.MOV = 1'b1; bus.ReadWrite = 1'b0; bus.Type = 2'b10;
        bus.Address = 9'h044; bus.DataIn = 32'hAAAAAAAA;
        @(posedge Clk); #2;
        Clr = 1'b1; #1;
        checks++;
        if (bus.MFC !== 1'b0 || bus.AlignErr !== 1'b0 || bus.DataOut !== 32'h0) begin
            errors++; $display("FAIL clr_async: MFC=%b AlignErr=%b DataOut=%h required 0/0/00000000",
                               bus.MFC, bus.AlignErr, bus.DataOut);
        end
        @(negedge Clk); bus.MOV = 1'b0;
        @(posedge Clk);
        @(negedge Clk); Clr = 1'b0;
        xact(1'b1, 2'b10, 9'h044, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h55667788) begin
            errors++; $display("FAIL clr_mem: q=%h required 55667788", q);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] q; logic ae; int e;
        xact(1'b0, 2'b10, 9'h1FC, 32'hCAFEF00D, q, ae, e);
        checks++;
        if (ae !== 1'b0 || e !== OK_EDGES) begin
            errors++; $display("FAIL top_write: ae=%b edges=%0d required 0/%0d", ae, e, OK_EDGES);
        end
        xact(1'b1, 2'b10, 9'h1FC, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'hCAFEF00D) begin
            errors++; $display("FAIL top_read: q=%h required cafef00d", q);
        end
        xact(1'b1, 2'b00, 9'h1FF, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h0000000D) begin
            errors++; $display("FAIL top_byte: q=%h required 0000000d", q);
        end
        xact(1'b1, 2'b10, 9'h000, 32'h0, q, ae, e);
        checks++;
        if (q !== 32'h11223344) begin
            errors++; $display("FAIL addr0_intact: q=%h required 11223344", q);
        end
    endtask

    initial begin
        bus.MOV = 1'b0; bus.ReadWrite = 1'b1; bus.Type = 2'b00;
        bus.Address = '0; bus.DataIn = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_handshake();
        test_abort_reset();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
